actuator_sequencer: RTL and testbench
=====================================

// Module: actuator_sequencer
// PURPOSE
//   Receiving end of the controller's actuator command bus (A1..A6). Turns raw
//   command bits into safe drive signals for the relay/SSR stage: enforces a
//   minimum ON and a minimum OFF dwell per actuator, staggers turn-ons to limit
//   inrush, and offers a global force-off. Sits between the environmental FSM
//   outputs and the FPGA pins driving the actuator relays.
// PARAMETERS
//   N_ACT    6          number of actuator channels (bit i = A(i+1))
//   ACT_MASK 6'b111101  channels allowed to drive; masked bits never assert (A2 unused)
//   MIN_ON   16'd1000   minimum cycles a drive bit stays 1 once asserted (>=1)
//   MIN_OFF  16'd1000   minimum cycles a drive bit stays 0 once deasserted (>=1)
//   STAGGER  16'd50     minimum cycles between two successive turn-on grants (>=1)
//   CNT_W    16         width of dwell and stagger counters; MIN_ON, MIN_OFF, STAGGER < 2**CNT_W
// PORTS
//   clk        in   1      system clock
//   reset      in   1      synchronous, active-high reset
//   cmd        in   N_ACT  requested actuator state from controller (1 = on)
//   force_off  in   1      emergency stop: drop all drives next edge
//   drive      out  N_ACT  registered actuator drive (1 = energise)
//   pending    out  N_ACT  combinational: (cmd & ACT_MASK) ^ drive, i.e. request not yet honoured
//   busy       out  1      combinational: |pending
// BEHAVIOUR
//   - One clock, clk. reset is synchronous and active-high. On reset: drive=0,
//     all dwell counters dcnt[i]=0, stagger counter stag=0. Channels are free to
//     turn on in the first cycle after reset releases; no MIN_OFF enforced.
//   - Per channel i: dwell counter dcnt[i] decrements by 1 each edge while nonzero.
//   - Turn-off: drive[i]=1, cmd[i]=0, dcnt[i]==0 -> drive[i]<=0, dcnt[i]<=MIN_OFF-1.
//     Turn-offs are not staggered; any number may occur on the same edge.
//   - Turn-on eligibility: drive[i]=0, cmd[i]&ACT_MASK[i]=1, dcnt[i]==0.
//   - Grant: if stag==0 and any channel eligible, lowest index wins: drive[i]<=1,
//     dcnt[i]<=MIN_ON-1, stag<=STAGGER-1. At most one grant per edge. stag
//     decrements by 1 each edge while nonzero.
//   - Resulting timing: drive high for >= MIN_ON cycles, low for >= MIN_OFF cycles,
//     successive rising edges of any two drive bits >= STAGGER cycles apart.
//   - Latency: cmd change to drive change is 1 cycle when unconstrained.
//   - Command glitch shorter than remaining dwell: ignored (drive holds state;
//     pending shows the mismatch).
//   - force_off=1 (priority over all else except reset): every drive<=0; channels
//     that were on load dcnt<=MIN_OFF-1; off channels keep counting; stag<=0.
//     While force_off stays 1 no grant is issued.
//   - Masked channel (ACT_MASK[i]=0): drive[i] constant 0, pending[i] constant 0.
//   - Reset mid-dwell: all state cleared on that edge as above.
//   - No per-channel FSM beyond (drive, dcnt): states OFF_LOCK (drive=0,dcnt!=0),
//     OFF_FREE, ON_LOCK (drive=1,dcnt!=0), ON_FREE.
// STRUCTURE
//   - Shared include env_ctrl_defs.vh: actuator index constants (ACT_EXHAUST=0,
//     ACT_INLINE=1, ACT_HUMID=2, ACT_DEHUMID=3, ACT_COOL=4, ACT_LED=5), default
//     ACT_MASK, N_ACT.
//   - Sub-module actuator_channel: one channel's drive/dcnt logic, inputs req, grant,
//     force_off, outputs drive, eligible; instantiated N_ACT times via generate.
//   - Top level holds stag counter and lowest-index grant priority encoder.
// TESTING (bench params: MIN_ON=4, MIN_OFF=3, STAGGER=3)
//   1 reset, then cmd=6'b000001 -> drive=6'b000001 one edge later; pending=0, busy=0.
//   2 cmd[0] high 1 cycle then low -> drive[0] high exactly 4 cycles; re-raise cmd[0]
//     at once -> drive[0] stays 0 for 3 cycles, then re-asserts.
//   3 cmd=6'b111111 in one cycle -> drive bits 0,2,3,4,5 rise at edges 1,4,7,10,13;
//     drive[1] never rises; pending[1]=0 throughout.
//   4 force_off pulse while drive=6'b111101 in ON_LOCK -> drive=0 next edge; cmd held
//     high -> bit 0 re-asserts 3 cycles after force_off release, others staggered by 3.
//   5 reset asserted mid-sequence of case 3 -> drive=0 next edge; with cmd still
//     6'b000100 after release -> drive[2]=1 one edge after release (no MIN_OFF wait).
//   6 toggle cmd[4] every cycle for 40 cycles -> drive[4] never high <4 or low <3
//     consecutive cycles; checker asserts dwell and stagger rules on all bits.

Source files
------------

// File: rtl/actuator_sequencer_pkg.sv
// Shared definitions for the actuator command bus receiver.
//   - Actuator index constants (bit i of cmd/drive = actuator A(i+1)).
//   - Default channel count and default enable mask (A2 / inline fan unused).
//   - Default counter width and the dwell reload helper.
package actuator_sequencer_pkg;

  localparam int N_ACT_DEF = 6;
  localparam int CNT_W_DEF = 16;
  localparam logic [N_ACT_DEF-1:0] ACT_MASK_DEF = 6'b111101;

  localparam int ACT_EXHAUST = 0;
  localparam int ACT_INLINE  = 1;
  localparam int ACT_HUMID   = 2;
  localparam int ACT_DEHUMID = 3;
  localparam int ACT_COOL    = 4;
  localparam int ACT_LED     = 5;

  // A counter loaded with (cycles-1) on the edge that starts a dwell holds
  // the new state for exactly 'cycles' cycles before the next change.
  function automatic int unsigned dwell_reload(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/actuator_channel.sv
// One actuator channel: drive register plus its dwell counter.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req         masked command bit (1 = actuator requested on)
//   grant       turn-on grant from the top-level priority encoder
//   force_off   emergency stop, drops drive on the next edge
//   drive       registered drive output
//   eligible    channel wants to turn on and its OFF dwell has expired
// The (drive, dcnt) pair forms four implicit states: OFF_LOCK (0, !=0),
// OFF_FREE (0, 0), ON_LOCK (1, !=0) and ON_FREE (1, 0).
module actuator_channel
  import actuator_sequencer_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned MIN_ON  = 1000,
  parameter int unsigned MIN_OFF = 1000,
  parameter bit          ENABLE  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic grant,
  input  logic force_off,
  output logic drive,
  output logic eligible
);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(dwell_reload(MIN_ON));
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(dwell_reload(MIN_OFF));

  logic             drive_q, drive_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             free;

  assign free = (dcnt_q == '0);

  always_comb begin
    drive_d = drive_q;
    dcnt_d  = free ? dcnt_q : dcnt_q - CNT_W'(1);
    if (force_off) begin
      // Off channels keep counting down their existing OFF dwell.
      if (drive_q) begin
        drive_d = 1'b0;
        dcnt_d  = OFF_LOAD;
      end
    end else if (drive_q && !req && free) begin
      drive_d = 1'b0;
      dcnt_d  = OFF_LOAD;
    end else if (grant) begin
      drive_d = 1'b1;
      dcnt_d  = ON_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drive_q <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      drive_q <= drive_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // A disabled channel can never be granted, so its drive stays 0.
  assign eligible = ENABLE && !drive_q && req && free;
  assign drive    = ENABLE && drive_q;

endmodule

// File: rtl/actuator_sequencer.sv
// Actuator sequencer: turns raw controller command bits into safe relay
// drive signals. Enforces per-channel minimum ON/OFF dwell, spaces turn-ons
// by at least STAGGER cycles to limit inrush, and provides a global force-off.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   cmd        requested actuator state (1 = on), bit i = A(i+1)
//   force_off  emergency stop: all drives drop on the next edge
//   drive      registered actuator drive (1 = energise)
//   pending    (cmd & ACT_MASK) ^ drive: requests not yet honoured
//   busy       |pending
module actuator_sequencer
  import actuator_sequencer_pkg::*;
#(
  parameter int               N_ACT    = N_ACT_DEF,
  parameter logic [N_ACT-1:0] ACT_MASK = N_ACT'(ACT_MASK_DEF),
  parameter int unsigned      MIN_ON   = 1000,
  parameter int unsigned      MIN_OFF  = 1000,
  parameter int unsigned      STAGGER  = 50,
  parameter int               CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_ACT-1:0] cmd,
  input  logic             force_off,
  output logic [N_ACT-1:0] drive,
  output logic [N_ACT-1:0] pending,
  output logic             busy
);

  localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(dwell_reload(STAGGER));

  logic [N_ACT-1:0] req;
  logic [N_ACT-1:0] elig;
  logic [N_ACT-1:0] grant;
  logic [N_ACT-1:0] drive_int;
  logic             grant_found;
  logic [CNT_W-1:0] stag_q, stag_d;

  assign req = cmd & ACT_MASK;

  for (genvar gi = 0; gi < N_ACT; gi++) begin : g_ch
    actuator_channel #(
      .CNT_W  (CNT_W),
      .MIN_ON (MIN_ON),
      .MIN_OFF(MIN_OFF),
      .ENABLE (ACT_MASK[gi])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .req      (req[gi]),
      .grant    (grant[gi]),
      .force_off(force_off),
      .drive    (drive_int[gi]),
      .eligible (elig[gi])
    );
  end

  // Lowest eligible index wins; at most one grant per edge, none while the
  // stagger window is open or force_off is held.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    if ((stag_q == '0) && !force_off) begin
      for (int i = 0; i < N_ACT; i++) begin
        if (elig[i] && !grant_found) begin
          grant[i]    = 1'b1;
          grant_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stag_d = stag_q;
    if (force_off) begin
      stag_d = '0;
    end else if (grant_found) begin
      stag_d = STAG_LOAD;
    end else if (stag_q != '0) begin
      stag_d = stag_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stag_q <= '0;
    end else begin
      stag_q <= stag_d;
    end
  end

  assign drive   = drive_int;
  assign pending = req ^ drive_int;
  assign busy    = |pending;

endmodule

// File: tb/tb_actuator_sequencer.sv
module tb_actuator_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] cmd;
  logic       force_off;
  logic [5:0] drive;
  logic [5:0] pending;
  logic       busy;

  int total = 0;
  int bad   = 0;

  actuator_sequencer #(
    .N_ACT   (6),
    .ACT_MASK(6'b111101),
    .MIN_ON  (4),
    .MIN_OFF (3),
    .STAGGER (3),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd),
    .force_off(force_off),
    .drive    (drive),
    .pending  (pending),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd       = 6'b0;
    force_off = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  int         ord [5] = '{0, 2, 3, 4, 5};
  logic [5:0] expd;
  logic [5:0] prev;
  int         run_len [6];
  logic       exempt [6];
  int         last_rise;
  int         rises4;
  int         high4;

  initial begin
    // Case 1: reset state and single-cycle latency
    do_reset();
    check("rst_drive", 16'(drive), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    cmd = 6'b000001;
    #1;
    check("c1_pend_before", 16'(pending), 16'h01);
    check("c1_busy_before", 16'(busy), 16'h1);
    step();
    check("c1_drive", 16'(drive), 16'h01);
    check("c1_pending", 16'(pending), 16'h0);
    check("c1_busy", 16'(busy), 16'h0);

    // Case 2: MIN_ON hold after a 1-cycle command, then MIN_OFF lockout
    cmd = 6'b000000;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("c2_on_hold", 16'(drive), 16'h01);
    end
    step();
    check("c2_off", 16'(drive), 16'h00);
    cmd = 6'b000001;
    for (int k = 1; k <= 2; k++) begin
      step();
      check("c2_off_hold", 16'(drive), 16'h00);
      check("c2_off_pend", 16'(pending), 16'h01);
    end
    step();
    check("c2_reassert", 16'(drive), 16'h01);

    // Case 3: stagger of all channels, masked channel stays idle
    do_reset();
    cmd  = 6'b111111;
    expd = 6'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if ((k % 3) == 1) expd[ord[(k-1)/3]] = 1'b1;
      check("c3_drive", 16'(drive), 16'(expd));
      check("c3_pend1", 16'(pending[1]), 16'h0);
    end

    // Case 4: force-off, then staggered recovery after MIN_OFF
    force_off = 1'b1;
    step();
    check("c4_forced", 16'(drive), 16'h00);
    force_off = 1'b0;
    expd = 6'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if ((k % 3) == 0) expd[ord[k/3-1]] = 1'b1;
      check("c4_recover", 16'(drive), 16'(expd));
    end

    // Case 5: reset mid-sequence clears dwell state
    do_reset();
    cmd = 6'b111111;
    for (int k = 1; k <= 5; k++) step();
    check("c5_before", 16'(drive), 16'h05);
    reset = 1'b1;
    cmd   = 6'b000100;
    step();
    check("c5_in_reset", 16'(drive), 16'h00);
    reset = 1'b0;
    step();
    check("c5_after", 16'(drive), 16'h04);

    // Case 6: toggle cmd[4] every cycle; watch dwell and stagger on all bits
    do_reset();
    prev      = drive;
    last_rise = -100;
    rises4    = 0;
    high4     = 0;
    for (int b = 0; b < 6; b++) begin
      run_len[b] = 0;
      exempt[b]  = 1'b1;
    end
    for (int t = 1; t <= 40; t++) begin
      cmd[4] = ~cmd[4];
      step();
      for (int b = 0; b < 6; b++) begin
        if (drive[b] !== prev[b]) begin
          if (prev[b]) begin
            check("c6_min_on", 16'(run_len[b] >= 4), 16'h1);
          end else if (!exempt[b]) begin
            check("c6_min_off", 16'(run_len[b] >= 3), 16'h1);
          end
          if (drive[b]) begin
            check("c6_stagger", 16'((t - last_rise) >= 3), 16'h1);
            last_rise = t;
            if (b == 4) rises4++;
          end
          exempt[b]  = 1'b0;
          run_len[b] = 1;
        end else begin
          run_len[b]++;
        end
      end
      if (drive[4]) high4++;
      prev = drive;
    end
    check("c6_rises", 16'(rises4), 16'd5);
    check("c6_high_cycles", 16'(high4), 16'd25);
    check("c6_others", 16'(drive & 6'b101111), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
